// File: rtl/frequency_dump_master.sv
// frequency_dump_master
//   AXI4-Lite master that asks a frequency-measurement slave to dump its
//   results. On start it writes DUMP_FREQUENCIES_REQUEST to CTRL_REG_ADDR,
//   waits for the write response, then reads RESULT_COUNT words starting at
//   RESULT_BASE_ADDR, one at a time. Each good read beat is presented on
//   result_data/result_index, qualified by a one-cycle result_valid strobe.
//   A slave error on B or R aborts the dump and sets the sticky error flag.
//
// Ports
//   m00_axi_aclk, m00_axi_aresetn : clock, async active-low reset
//   start        : dump request, sampled only while idle
//   busy         : high whenever a dump is in progress
//   done         : one-cycle pulse when a dump ends (good or bad)
//   error        : sticky slave-error flag, cleared by the next accepted start
//   result_data  : captured read data
//   result_index : index of the word in result_data
//   result_valid : one-cycle strobe qualifying result_data/result_index
//   m00_axi_*    : AXI4-Lite master channels (AW, W, B, AR, R)
module frequency_dump_master #(
  parameter int DUMP_FREQUENCIES_REQUEST = 666,
  parameter int C_M00_AXI_DATA_WIDTH     = 32,
  parameter int C_M00_AXI_ADDR_WIDTH     = 5,
  parameter int CTRL_REG_ADDR            = 0,
  parameter int RESULT_BASE_ADDR         = 4,
  parameter int RESULT_COUNT             = 6
) (
  input  logic                                m00_axi_aclk,
  input  logic                                m00_axi_aresetn,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                error,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]     result_data,
  output logic [2:0]                          result_index,
  output logic                                result_valid,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [2:0]                          m00_axi_awprot,
  output logic                                m00_axi_awvalid,
  input  logic                                m00_axi_awready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_M00_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                                m00_axi_wvalid,
  input  logic                                m00_axi_wready,
  input  logic [1:0]                          m00_axi_bresp,
  input  logic                                m00_axi_bvalid,
  output logic                                m00_axi_bready,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
  output logic [2:0]                          m00_axi_arprot,
  output logic                                m00_axi_arvalid,
  input  logic                                m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
  input  logic [1:0]                          m00_axi_rresp,
  input  logic                                m00_axi_rvalid,
  output logic                                m00_axi_rready
);

  localparam int AW = C_M00_AXI_ADDR_WIDTH;
  localparam int DW = C_M00_AXI_DATA_WIDTH;

  localparam logic [AW-1:0] CTRL_ADDR = AW'(CTRL_REG_ADDR);
  localparam logic [AW-1:0] RES_BASE  = AW'(RESULT_BASE_ADDR);
  localparam logic [DW-1:0] CMD_WORD  = DW'(DUMP_FREQUENCIES_REQUEST);
  localparam logic [2:0]    LAST_IDX  = 3'(RESULT_COUNT - 1);
  localparam logic [1:0]    RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_FINISH
  } state_t;

  state_t state, state_nxt;

  logic          aw_vld, w_vld, ar_vld;
  logic          aw_done, w_done;   // handshake already completed this write
  logic [2:0]    idx;
  logic          aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic [AW-1:0] rd_addr;

  assign aw_hs = aw_vld & m00_axi_awready;
  assign w_hs  = w_vld  & m00_axi_wready;
  assign ar_hs = ar_vld & m00_axi_arready;
  assign b_hs  = m00_axi_bready & m00_axi_bvalid;
  assign r_hs  = m00_axi_rready & m00_axi_rvalid;

  // Wraps silently at the address width.
  assign rd_addr = RES_BASE + AW'({idx, 2'b00});

  // Address/data buses are zero unless their valid is up, so they read as
  // zero in reset and idle and stay stable for the whole valid window.
  assign m00_axi_awvalid = aw_vld;
  assign m00_axi_awaddr  = aw_vld ? CTRL_ADDR : '0;
  assign m00_axi_awprot  = 3'b000;
  assign m00_axi_wvalid  = w_vld;
  assign m00_axi_wdata   = w_vld ? CMD_WORD : '0;
  assign m00_axi_wstrb   = w_vld ? '1 : '0;
  assign m00_axi_bready  = (state == S_WRESP);
  assign m00_axi_arvalid = ar_vld;
  assign m00_axi_araddr  = ar_vld ? rd_addr : '0;
  assign m00_axi_arprot  = 3'b000;
  assign m00_axi_rready  = (state == S_RDATA);

  assign busy = (state != S_IDLE);
  assign done = (state == S_FINISH);

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) state <= S_IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_WRITE;
      // AW and W may complete in either order or together.
      S_WRITE:  if ((aw_done | aw_hs) && (w_done | w_hs)) state_nxt = S_WRESP;
      S_WRESP:  if (b_hs) state_nxt = (m00_axi_bresp == RESP_OKAY) ? S_RADDR : S_FINISH;
      S_RADDR:  if (ar_hs) state_nxt = S_RDATA;
      S_RDATA: begin
        if (r_hs) begin
          if (m00_axi_rresp != RESP_OKAY) state_nxt = S_FINISH;
          else if (idx < LAST_IDX)        state_nxt = S_RADDR;
          else                            state_nxt = S_FINISH;
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      aw_vld       <= 1'b0;
      w_vld        <= 1'b0;
      ar_vld       <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      idx          <= '0;
      error        <= 1'b0;
      result_data  <= '0;
      result_index <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            error   <= 1'b0;
            idx     <= '0;
            aw_vld  <= 1'b1;
            w_vld   <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        S_WRITE: begin
          if (aw_hs) begin
            aw_vld  <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            w_vld  <= 1'b0;
            w_done <= 1'b1;
          end
        end
        S_WRESP: begin
          if (b_hs) begin
            if (m00_axi_bresp == RESP_OKAY) ar_vld <= 1'b1;
            else                            error  <= 1'b1;
          end
        end
        S_RADDR: begin
          if (ar_hs) ar_vld <= 1'b0;
        end
        S_RDATA: begin
          if (r_hs) begin
            if (m00_axi_rresp == RESP_OKAY) begin
              result_data  <= m00_axi_rdata;
              result_index <= idx;
              result_valid <= 1'b1;
              if (idx < LAST_IDX) begin
                idx    <= idx + 3'd1;
                ar_vld <= 1'b1;
              end
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frequency_dump_master.sv
// Bench for frequency_dump_master: a table of dump scenarios (slave delays,
// response codes, expected read/result counts and error flag) driven through
// a cycle-stepped AXI4-Lite slave model, plus reset corner sequences.
module tb_frequency_dump_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error, result_valid;
  logic [31:0] result_data;
  logic [2:0]  result_index;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, arvalid, bready, rready;
  logic        awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [31:0] wdata;
  logic [31:0] rdata = 0;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = 0, rresp = 0;

  always #5 clk = ~clk;

  frequency_dump_master dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n), .start(start),
    .busy(busy), .done(done), .error(error), .result_data(result_data),
    .result_index(result_index), .result_valid(result_valid),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid),
    .m00_axi_awready(awready), .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready), .m00_axi_bresp(bresp),
    .m00_axi_bvalid(bvalid), .m00_axi_bready(bready), .m00_axi_araddr(araddr),
    .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid),
    .m00_axi_rready(rready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    string      name;
    int         aw_dly;
    int         w_dly;
    logic [1:0] b_resp;
    int         fail_idx;   // read index answered with SLVERR/DECERR (7 = none)
    bit         rnd;        // random AR/R stalls 0..5
    bit         hold;       // keep start high for the whole dump
    int         exp_reads;
    int         exp_res;
    bit         exp_err;
  } vec_t;

  // slave model state
  int         aw_dly, w_dly, ar_dly, r_dly, fail_idx;
  bit         rnd;
  logic [1:0] b_resp;
  int         aw_cnt, w_cnt, ar_cnt, r_cnt;
  int         n_aw, n_w, n_b, n_ar, n_r, n_res, rd_idx;
  bit         b_pend, b_issued, r_pend, ar_stall, aw_drop, w_drop;
  logic [4:0] last_araddr;

  task automatic slave_reset(input vec_t v);
    aw_dly = v.aw_dly; w_dly = v.w_dly; b_resp = v.b_resp;
    fail_idx = v.fail_idx; rnd = v.rnd;
    ar_dly = rnd ? int'($urandom_range(0, 5)) : 0;
    r_dly  = rnd ? int'($urandom_range(0, 5)) : 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; n_res = 0; rd_idx = 0;
    b_pend = 0; b_issued = 0; r_pend = 0; ar_stall = 0; aw_drop = 0; w_drop = 0;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
  endtask

  // Called on each falling edge: check what the last rising edge produced,
  // then set slave inputs for the next rising edge.
  task automatic slave_step();
    bit new_r;
    new_r = 0;
    if (aw_drop) chk("awvalid_drop", 32'(awvalid), 0);
    if (w_drop)  chk("wvalid_drop", 32'(wvalid), 0);
    aw_drop = 0; w_drop = 0;
    if (ar_stall) begin
      chk("arvalid_held", 32'(arvalid), 1);
      chk("araddr_stable", 32'(araddr), 32'(last_araddr));
    end
    if (result_valid) begin
      chk("res_index", 32'(result_index), 32'(n_res));
      chk("res_data", result_data, 32'h100 + 32'(n_res));
      n_res++;
    end
    // write address / data
    awready = awvalid && (aw_cnt >= aw_dly);
    if (awvalid && !awready) aw_cnt++;
    if (awvalid && awready) begin
      n_aw++; aw_drop = 1;
      chk("awaddr", 32'(awaddr), 0);
      chk("awprot", 32'(awprot), 0);
    end
    wready = wvalid && (w_cnt >= w_dly);
    if (wvalid && !wready) w_cnt++;
    if (wvalid && wready) begin
      n_w++; w_drop = 1;
      chk("wdata", wdata, 666);
      chk("wstrb", 32'(wstrb), 4'hF);
    end
    // write response
    bvalid = b_pend;
    bresp  = b_resp;
    if (bvalid && bready) begin n_b++; b_pend = 0; end
    // read data (for the address accepted earlier)
    rvalid = r_pend && (r_cnt >= r_dly);
    rdata  = 32'h100 + 32'(rd_idx);
    rresp  = (rd_idx == fail_idx) ? 2'b11 : 2'b00;
    if (r_pend && !rvalid) r_cnt++;
    if (rvalid && rready) begin n_r++; r_pend = 0; end
    // read address
    arready = arvalid && (ar_cnt >= ar_dly);
    ar_stall = arvalid && !arready;
    last_araddr = araddr;
    if (ar_stall) ar_cnt++;
    if (arvalid && arready) begin
      chk("araddr", 32'(araddr), 32'(4 + 4 * n_ar));
      chk("arprot", 32'(arprot), 0);
      rd_idx = n_ar; n_ar++; ar_cnt = 0; r_cnt = 0; new_r = 1;
      if (rnd) begin
        ar_dly = int'($urandom_range(0, 5));
        r_dly  = int'($urandom_range(0, 5));
      end
    end
    if (new_r) r_pend = 1;
    if (n_aw == 1 && n_w == 1 && !b_issued) begin b_pend = 1; b_issued = 1; end
  endtask

  task automatic run_dump(input vec_t v);
    bit seen;
    seen = 0;
    slave_reset(v);
    @(negedge clk);
    start = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (!v.hold) start = 0;
      if (cyc == 0) begin
        chk({v.name, ":busy_on_start"}, 32'(busy), 1);
        chk({v.name, ":error_cleared"}, 32'(error), 0);
      end
      slave_step();
      if (done) begin seen = 1; break; end
    end
    chk({v.name, ":done_seen"}, 32'(seen), 1);
    chk({v.name, ":n_aw"}, 32'(n_aw), 1);
    chk({v.name, ":n_w"}, 32'(n_w), 1);
    chk({v.name, ":n_b"}, 32'(n_b), 1);
    chk({v.name, ":n_ar"}, 32'(n_ar), 32'(v.exp_reads));
    chk({v.name, ":n_res"}, 32'(n_res), 32'(v.exp_res));
    chk({v.name, ":error"}, 32'(error), 32'(v.exp_err));
    @(negedge clk);
    start = 0;
    chk({v.name, ":done_one_cycle"}, 32'(done), 0);
    chk({v.name, ":idle_busy"}, 32'(busy), 0);
    chk({v.name, ":error_sticky"}, 32'(error), 32'(v.exp_err));
    @(negedge clk);
    chk({v.name, ":no_restart"}, 32'(busy | awvalid | arvalid), 0);
    chk({v.name, ":no_late_ar"}, 32'(n_ar), 32'(v.exp_reads));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ":busy"}, 32'(busy), 0);
    chk({tag, ":done"}, 32'(done), 0);
    chk({tag, ":error"}, 32'(error), 0);
    chk({tag, ":result_valid"}, 32'(result_valid), 0);
    chk({tag, ":result_data"}, result_data, 0);
    chk({tag, ":result_index"}, 32'(result_index), 0);
    chk({tag, ":valids"}, 32'({awvalid, wvalid, arvalid}), 0);
    chk({tag, ":readies"}, 32'({bready, rready}), 0);
    chk({tag, ":awaddr"}, 32'(awaddr), 0);
    chk({tag, ":araddr"}, 32'(araddr), 0);
    chk({tag, ":wdata"}, wdata, 0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"basic",      0, 0, 2'b00, 7, 0, 0, 6, 6, 0};
    vecs[1] = '{"aw_first",   0, 3, 2'b00, 7, 0, 0, 6, 6, 0};
    vecs[2] = '{"w_first",    2, 0, 2'b00, 7, 0, 0, 6, 6, 0};
    vecs[3] = '{"bresp_err",  0, 0, 2'b10, 7, 0, 0, 0, 0, 1};
    vecs[4] = '{"rresp_idx2", 1, 1, 2'b00, 2, 0, 0, 3, 2, 1};
    vecs[5] = '{"rand_hold",  0, 0, 2'b00, 7, 1, 1, 6, 6, 0};
    vecs[6] = '{"rresp_idx0", 0, 0, 2'b00, 0, 0, 0, 1, 0, 1};
    vecs[7] = '{"rresp_last", 0, 0, 2'b00, 5, 1, 0, 6, 5, 1};

    // reset state, with start requested while still in reset
    start = 1;
    #12;
    chk_reset_outputs("por");
    start = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("idle_no_start", 32'(busy | awvalid | arvalid), 0);

    for (int i = 0; i < 8; i++) run_dump(vecs[i]);

    // asynchronous reset while waiting on read data, after two results
    begin
      bit hit;
      int act;
      hit = 0;
      act = 0;
      slave_reset(vecs[0]);
      r_dly = 3;
      @(negedge clk);
      start = 1;
      for (int cyc = 0; cyc < 200; cyc++) begin
        @(negedge clk);
        start = 0;
        slave_step();
        if (n_res >= 2 && rready) begin hit = 1; break; end
      end
      chk("reach_rdata", 32'(hit), 1);
      chk("pre_reset_data", result_data, 32'h101);
      #2 rst_n = 0;
      #1 chk_reset_outputs("mid_reset");
      slave_reset(vecs[0]);
      @(negedge clk);
      rst_n = 1;
      for (int cyc = 0; cyc < 10; cyc++) begin
        @(negedge clk);
        slave_step();
        if (busy || awvalid || wvalid || arvalid) act++;
      end
      chk("quiet_after_reset", 32'(act), 0);
    end

    // a fresh start after the reset still works
    run_dump(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
